// File: rtl/branch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : branch_ctrl
// Description : RV32I branch/jump resolution controller. Accepts a request in
//               IDLE and drives the latched operands to an external comparator
//               for one cycle (CMP). It then strobes the resolution (RES). A
//               taken branch or jump is followed by a 2-cycle pipeline flush
//               (FLUSH).
// Ports       : clk, rst_n           - clock, synchronous active-low reset
//               br_valid / br_ready  - request handshake
//               is_jump, funct3      - request kind (jump or branch funct3)
//               rs1, rs2             - branch operands
//               cmp_a, cmp_b, BrUn   - comparator operands / unsigned select
//               BrEq, BrLt           - comparator results (combinational)
//               PCSel, done          - target select, one-cycle resolve strobe
//               flush                - kill younger pipeline instructions
//               illegal              - reserved branch funct3 (010/011) pulse
//               taken_cnt            - saturating count of taken branches
// Revision    : 1.0 - initial release
// ============================================================================
module branch_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        br_valid,
    output logic        br_ready,
    input  logic        is_jump,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic [31:0] cmp_a,
    output logic [31:0] cmp_b,
    output logic        BrUn,
    input  logic        BrEq,
    input  logic        BrLt,
    output logic        PCSel,
    output logic        done,
    output logic        flush,
    output logic        illegal,
    output logic [15:0] taken_cnt
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_CMP   = 2'd1;
    localparam logic [1:0] c_RES   = 2'd2;
    localparam logic [1:0] c_FLUSH = 2'd3;

    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    logic [1:0]  r_state;
    logic        r_ready;
    logic [31:0] r_cmpA;
    logic [31:0] r_cmpB;
    logic        r_brUn;
    logic [2:0]  r_funct3;
    logic        r_isJump;
    logic        r_taken;
    logic        r_pcSel;
    logic        r_done;
    logic        r_flush;
    logic        r_flushCnt;
    logic        r_illegal;
    logic [15:0] r_takenCnt;

    logic        w_taken;
    logic        w_illegal;

    // Decision from the latched request; only consumed while in CMP, when
    // the comparator is looking at the latched operands.
    always_comb begin
        w_taken = 1'b0;
        if (r_isJump) begin
            w_taken = 1'b1;
        end else begin
            case (r_funct3)
                3'b000:         w_taken = BrEq;
                3'b001:         w_taken = !BrEq;
                3'b100, 3'b110: w_taken = BrLt;
                3'b101, 3'b111: w_taken = !BrLt;
                default:        w_taken = 1'b0;
            endcase
        end
    end

    assign w_illegal = !r_isJump && (r_funct3[2:1] == 2'b01);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_ready    <= 1'b1;
            r_cmpA     <= 32'd0;
            r_cmpB     <= 32'd0;
            r_brUn     <= 1'b0;
            r_funct3   <= 3'd0;
            r_isJump   <= 1'b0;
            r_taken    <= 1'b0;
            r_pcSel    <= 1'b0;
            r_done     <= 1'b0;
            r_flush    <= 1'b0;
            r_flushCnt <= 1'b0;
            r_illegal  <= 1'b0;
            r_takenCnt <= 16'd0;
        end else begin
            // One-cycle strobes fall back to 0 unless re-asserted below.
            r_done    <= 1'b0;
            r_pcSel   <= 1'b0;
            r_illegal <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (br_valid && r_ready) begin
                        // The comparator operand registers double as the
                        // latched rs1/rs2, so they are held while busy.
                        r_cmpA   <= rs1;
                        r_cmpB   <= rs2;
                        r_brUn   <= funct3[2] & funct3[1];
                        r_funct3 <= funct3;
                        r_isJump <= is_jump;
                        r_ready  <= 1'b0;
                        r_state  <= c_CMP;
                    end
                end
                c_CMP: begin
                    r_taken   <= w_taken;
                    r_done    <= 1'b1;
                    r_pcSel   <= w_taken;
                    r_illegal <= w_illegal;
                    r_state   <= c_RES;
                end
                c_RES: begin
                    if (r_taken) begin
                        if (r_takenCnt != c_CNT_MAX) begin
                            r_takenCnt <= r_takenCnt + 16'd1;
                        end
                        r_flush    <= 1'b1;
                        r_flushCnt <= 1'b0;
                        r_state    <= c_FLUSH;
                    end else begin
                        r_ready <= 1'b1;
                        r_state <= c_IDLE;
                    end
                end
                c_FLUSH: begin
                    if (r_flushCnt) begin
                        r_flush <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= c_IDLE;
                    end else begin
                        r_flushCnt <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    // Gating with rst_n keeps the controller from advertising readiness
    // while reset is being held.
    assign br_ready  = r_ready & rst_n;
    assign cmp_a     = r_cmpA;
    assign cmp_b     = r_cmpB;
    assign BrUn      = r_brUn;
    assign PCSel     = r_pcSel;
    assign done      = r_done;
    assign flush     = r_flush;
    assign illegal   = r_illegal;
    assign taken_cnt = r_takenCnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_ctrl
// Description : Directed self-checking bench for branch_ctrl. Models the
//               external comparator and checks timing, decisions, flush,
//               reset abort and counter saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        br_valid;
    logic        br_ready;
    logic        is_jump;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] cmp_a;
    logic [31:0] cmp_b;
    logic        BrUn;
    logic        BrEq;
    logic        BrLt;
    logic        PCSel;
    logic        done;
    logic        flush;
    logic        illegal;
    logic [15:0] taken_cnt;

    int checks = 0;
    int errors = 0;
    logic [15:0] expCnt = 16'd0;

    // Observations from one issued request, by cycle after the handshake edge.
    logic        oBrUn, oDone, oPc, oIll, oDone2, oPc2, oFlush3, oFlush4, oFlush5;
    logic        oRdy3, oRdy5;
    logic [31:0] oCmpA, oCmpB;
    logic [15:0] oCnt;

    typedef struct packed {
        logic        isj;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic        tk;
        logic        un;
        logic        ill;
    } vec_t;

    branch_ctrl dut (
        .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ready(br_ready),
        .is_jump(is_jump), .funct3(funct3), .rs1(rs1), .rs2(rs2),
        .cmp_a(cmp_a), .cmp_b(cmp_b), .BrUn(BrUn), .BrEq(BrEq), .BrLt(BrLt),
        .PCSel(PCSel), .done(done), .flush(flush), .illegal(illegal),
        .taken_cnt(taken_cnt)
    );

    // External comparator.
    assign BrEq = (cmp_a == cmp_b);
    assign BrLt = BrUn ? (cmp_a < cmp_b) : ($signed(cmp_a) < $signed(cmp_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic waitReady();
        int n;
        n = 0;
        while (br_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (br_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_timeout: br_ready=%b required 1", br_ready);
        end
    endtask

    // Issue one request and record outputs on the following five cycles.
    // Inputs are scrambled after the handshake to expose any re-latching.
    task automatic doBranch(input logic isj, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        waitReady();
        is_jump = isj; funct3 = f3; rs1 = a; rs2 = b; br_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        oBrUn = BrUn; oCmpA = cmp_a; oCmpB = cmp_b;
        br_valid = 1'b0; rs1 = ~a; rs2 = ~b; funct3 = ~f3; is_jump = ~isj;
        @(negedge clk);
        oDone = done; oPc = PCSel; oIll = illegal;
        @(negedge clk);
        oDone2 = done; oPc2 = PCSel; oFlush3 = flush; oRdy3 = br_ready;
        @(negedge clk);
        oFlush4 = flush;
        @(negedge clk);
        oFlush5 = flush; oRdy5 = br_ready; oCnt = taken_cnt;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; br_valid = 1'b1; is_jump = 1'b1; funct3 = 3'd0;
        rs1 = 32'hDEAD_BEEF; rs2 = 32'h1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (br_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b required 0", br_ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b required 0", done); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rst_flush: got %b required 0", flush); end
        checks++; if (PCSel !== 1'b0) begin errors++; $display("FAIL rst_pcsel: got %b required 0", PCSel); end
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL rst_illegal: got %b required 0", illegal); end
        checks++; if (taken_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt: got %h required 0000", taken_cnt); end
        checks++; if (cmp_a !== 32'd0 || cmp_b !== 32'd0) begin errors++; $display("FAIL rst_cmp: got %h/%h required 0/0", cmp_a, cmp_b); end
        checks++; if (BrUn !== 1'b0) begin errors++; $display("FAIL rst_brun: got %b required 0", BrUn); end
        br_valid = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        checks++; if (br_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %b required 1", br_ready); end
        checks++; if (cmp_a !== 32'd0) begin errors++; $display("FAIL rst_no_accept: cmp_a got %h required 0", cmp_a); end
    endtask

    task automatic test_directed();
        vec_t v [13];
        v[0]  = '{1'b0, 3'b000, 32'h0000_1234, 32'h0000_1234, 1'b1, 1'b0, 1'b0}; // BEQ equal
        v[1]  = '{1'b0, 3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1'b0}; // BLT -1<1
        v[2]  = '{1'b0, 3'b110, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b0}; // BLTU
        v[3]  = '{1'b0, 3'b001, 32'h0000_0005, 32'h0000_0005, 1'b0, 1'b0, 1'b0}; // BNE equal
        v[4]  = '{1'b0, 3'b001, 32'h0000_0005, 32'h0000_0006, 1'b1, 1'b0, 1'b0}; // BNE differ
        v[5]  = '{1'b0, 3'b101, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0}; // BGE -1>=1
        v[6]  = '{1'b0, 3'b111, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b1, 1'b0}; // BGEU
        v[7]  = '{1'b0, 3'b000, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 1'b0}; // BEQ differ
        v[8]  = '{1'b0, 3'b010, 32'h0000_0007, 32'h0000_0007, 1'b0, 1'b0, 1'b1}; // reserved
        v[9]  = '{1'b1, 3'b010, 32'h0000_0007, 32'h0000_0008, 1'b1, 1'b0, 1'b0}; // jump
        v[10] = '{1'b0, 3'b011, 32'h0000_0003, 32'h0000_0003, 1'b0, 1'b0, 1'b1}; // reserved
        v[11] = '{1'b1, 3'b000, 32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0, 1'b0}; // jump
        v[12] = '{1'b0, 3'b100, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0}; // BLT 1<-1
        for (int i = 0; i < 13; i++) begin
            doBranch(v[i].isj, v[i].f3, v[i].a, v[i].b);
            if (v[i].tk) expCnt = expCnt + 16'd1;
            checks++; if (oCmpA !== v[i].a || oCmpB !== v[i].b) begin errors++; $display("FAIL vec%0d_cmp: got %h/%h required %h/%h", i, oCmpA, oCmpB, v[i].a, v[i].b); end
            checks++; if (oBrUn !== v[i].un) begin errors++; $display("FAIL vec%0d_brun: got %b required %b", i, oBrUn, v[i].un); end
            checks++; if (oDone !== 1'b1) begin errors++; $display("FAIL vec%0d_done: got %b required 1", i, oDone); end
            checks++; if (oPc !== v[i].tk) begin errors++; $display("FAIL vec%0d_pcsel: got %b required %b", i, oPc, v[i].tk); end
            checks++; if (oIll !== v[i].ill) begin errors++; $display("FAIL vec%0d_illegal: got %b required %b", i, oIll, v[i].ill); end
            checks++; if (oDone2 !== 1'b0 || oPc2 !== 1'b0) begin errors++; $display("FAIL vec%0d_strobe_len: done=%b pcsel=%b required 0/0", i, oDone2, oPc2); end
            checks++; if (oFlush3 !== v[i].tk || oFlush4 !== v[i].tk) begin errors++; $display("FAIL vec%0d_flush: got %b%b required %b%b", i, oFlush3, oFlush4, v[i].tk, v[i].tk); end
            checks++; if (oFlush5 !== 1'b0) begin errors++; $display("FAIL vec%0d_flush_end: got %b required 0", i, oFlush5); end
            checks++; if (oRdy3 !== !v[i].tk) begin errors++; $display("FAIL vec%0d_ready3: got %b required %b", i, oRdy3, !v[i].tk); end
            checks++; if (oRdy5 !== 1'b1) begin errors++; $display("FAIL vec%0d_ready5: got %b required 1", i, oRdy5); end
            checks++; if (oCnt !== expCnt) begin errors++; $display("FAIL vec%0d_cnt: got %h required %h", i, oCnt, expCnt); end
        end
    endtask

    // br_valid held high while rs1 changes every cycle; accepts must follow
    // the 3-cycle (not taken) or 5-cycle (taken) cadence and use the
    // rs1 value present at each accept edge.
    task automatic test_back_to_back(input logic isj, input int n, input logic [7:0] expRdy);
        logic rdy;
        int   accepts;
        int   k;
        accepts = 0;
        @(negedge clk);
        waitReady();
        is_jump = isj; funct3 = 3'b000; rs2 = 32'd0; br_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            rs1 = 32'hA000_0000 + i;
            rdy = br_ready;
            checks++; if (rdy !== expRdy[i]) begin errors++; $display("FAIL b2b_j%0d_ready[%0d]: got %b required %b", isj, i, rdy, expRdy[i]); end
            @(posedge clk);
            @(negedge clk);
            if (expRdy[i]) begin
                accepts++;
                checks++; if (cmp_a !== 32'hA000_0000 + i) begin errors++; $display("FAIL b2b_j%0d_cmpa[%0d]: got %h required %h", isj, i, cmp_a, 32'hA000_0000 + i); end
            end
        end
        br_valid = 1'b0;
        k = 0;
        while (!(br_ready === 1'b1 && flush === 1'b0) && k < 20) begin
            @(negedge clk);
            k++;
        end
        checks++; if (br_ready !== 1'b1) begin errors++; $display("FAIL b2b_drain: br_ready=%b required 1", br_ready); end
        if (isj) expCnt = expCnt + 16'(accepts);
        checks++; if (taken_cnt !== expCnt) begin errors++; $display("FAIL b2b_j%0d_cnt: got %h required %h", isj, taken_cnt, expCnt); end
    endtask

    task automatic test_reset_abort();
        // Reset during the first FLUSH cycle.
        @(negedge clk);
        waitReady();
        is_jump = 1'b1; funct3 = 3'b000; rs1 = 32'h11; rs2 = 32'h22; br_valid = 1'b1;
        @(posedge clk);
        @(negedge clk); br_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL abort_flush_pre: got %b required 1", flush); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL abort_flush: got %b required 0", flush); end
        checks++; if (taken_cnt !== 16'd0) begin errors++; $display("FAIL abort_cnt: got %h required 0000", taken_cnt); end
        checks++; if (cmp_a !== 32'd0) begin errors++; $display("FAIL abort_cmpa: got %h required 0", cmp_a); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (br_ready !== 1'b1 || flush !== 1'b0) begin errors++; $display("FAIL abort_idle: ready=%b flush=%b required 1/0", br_ready, flush); end
        expCnt = 16'd0;
        // Reset during CMP: the pending done must never appear.
        is_jump = 1'b1; br_valid = 1'b1;
        @(posedge clk);
        @(negedge clk); br_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        checks++; if (done !== 1'b0 || PCSel !== 1'b0) begin errors++; $display("FAIL abort_cmp_done: done=%b pcsel=%b required 0/0", done, PCSel); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (done !== 1'b0 || flush !== 1'b0 || br_ready !== 1'b1) begin errors++; $display("FAIL abort_cmp_idle: done=%b flush=%b ready=%b required 0/0/1", done, flush, br_ready); end
    endtask

    task automatic test_saturation();
        @(negedge clk);
        force dut.r_takenCnt = 16'hFFFE;
        #1;
        release dut.r_takenCnt;
        @(negedge clk);
        checks++; if (taken_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_preload: got %h required fffe", taken_cnt); end
        for (int i = 0; i < 3; i++) begin
            doBranch(1'b1, 3'b000, 32'h0, 32'h1);
            checks++; if (oCnt !== 16'hFFFF) begin errors++; $display("FAIL sat_cnt[%0d]: got %h required ffff", i, oCnt); end
        end
    endtask

    initial begin
        rst_n = 1'b0; br_valid = 1'b0; is_jump = 1'b0; funct3 = 3'd0;
        rs1 = 32'd0; rs2 = 32'd0;
        test_reset();
        test_directed();
        test_back_to_back(1'b0, 7, 8'b0100_1001);
        test_back_to_back(1'b1, 6, 8'b0010_0001);
        test_reset_abort();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset, sampled on clk rising edge.
REQ-003 SHALL have port br_valid, input, 1 bit: a branch or jump request is present.
REQ-004 SHALL have port br_ready, output, 1 bit: the controller can accept a request.
REQ-005 SHALL have port is_jump, input, 1 bit: unconditional jump (JAL/JALR); when high, funct3 is ignored.
REQ-006 SHALL have port funct3, input, 3 bits: RV32I branch funct3.
REQ-007 SHALL have ports rs1 and rs2, inputs, 32 bits each: branch operands.
REQ-008 SHALL have ports cmp_a and cmp_b, outputs, 32 bits each: operands driven to the branch comparator.
REQ-009 SHALL have port BrUn, output, 1 bit: unsigned-compare select driven to the comparator.
REQ-010 SHALL have ports BrEq and BrLt, inputs, 1 bit each: comparator results; they are combinational from cmp_a, cmp_b and BrUn.
REQ-011 SHALL have port PCSel, output, 1 bit: 1 selects the branch target, 0 selects PC+4; valid while done=1.
REQ-012 SHALL have port done, output, 1 bit: one-cycle resolution strobe.
REQ-013 SHALL have port flush, output, 1 bit: kill the younger pipeline instructions.
REQ-014 SHALL have port illegal, output, 1 bit: one-cycle pulse when funct3 is 010 or 011 and is_jump=0.
REQ-015 SHALL have port taken_cnt, output, 16 bits: count of taken branches and jumps.

Function
REQ-016 SHALL implement a four-state FSM: IDLE, CMP, RES and FLUSH.
REQ-017 SHALL assert br_ready=1 only in IDLE; a handshake occurs when br_valid=1 and br_ready=1 on a clk edge.
REQ-018 On a handshake, SHALL latch rs1, rs2, funct3 and is_jump into internal registers and go IDLE to CMP.
REQ-019 SHALL ignore br_valid in every state other than IDLE, and SHALL NOT latch the inputs while busy.
REQ-020 In CMP, SHALL drive cmp_a and cmp_b from the latched operands and drive BrUn = latched funct3[2] AND funct3[1].
- cmp_a, cmp_b and BrUn SHALL hold their last values in all other states (0 after reset).
REQ-021 At the end of CMP, SHALL register the taken decision from BrEq and BrLt, then go to RES:
- 000: taken = BrEq
- 001: taken = !BrEq
- 100 and 110: taken = BrLt
- 101 and 111: taken = !BrLt
- 010 and 011: taken = 0
- is_jump=1: taken = 1
REQ-022 In RES, SHALL assert done=1 for exactly one cycle and set PCSel=taken; PCSel SHALL be 0 outside RES.
REQ-023 In RES, SHALL assert illegal=1 for the cases in REQ-014.
REQ-024 From RES, SHALL go to FLUSH if taken=1, else to IDLE.
REQ-025 In FLUSH, SHALL hold flush=1 for exactly 2 cycles using a 1-bit counter, then go to IDLE; flush SHALL be 0 in all other states.
REQ-026 SHALL increment taken_cnt by 1 in each RES cycle with taken=1.
- taken_cnt SHALL saturate at 16'hFFFF and never wrap.
REQ-027 Timing from the handshake edge (cycle 0):
- not taken: done at cycle 2; br_ready=1 again at cycle 3; throughput one branch per 3 cycles.
- taken: done at cycle 2; flush at cycles 3 and 4; br_ready=1 again at cycle 5.
REQ-028 If br_valid is held high in IDLE, SHALL accept back-to-back requests with no bubble beyond REQ-027.

Reset
REQ-029 When rst_n=0 at a clk edge, SHALL go to IDLE and clear every output, flag, counter and latched register to 0, with br_ready=1 the cycle after.
- This applies in any state, including mid-CMP, mid-RES and mid-FLUSH, where the pending done or flush SHALL be aborted.
REQ-030 While rst_n=0, SHALL hold br_ready=0 and SHALL NOT accept requests.

Verification
REQ-031 BEQ with funct3=000, rs1=rs2=0x0000_1234 -> done at cycle 2 with PCSel=1; flush at cycles 3 and 4; taken_cnt=1.
REQ-032 BLT with funct3=100, rs1=0xFFFF_FFFF (-1), rs2=1 -> BrUn=0 during CMP; PCSel=1.
- BLTU with funct3=110 and the same operands -> BrUn=1; PCSel=0; no flush; br_ready=1 at cycle 3.
REQ-033 funct3=010 with is_jump=0 -> illegal=1 and done=1 in the same cycle, PCSel=0, no flush.
- funct3=010 with is_jump=1 -> PCSel=1, illegal=0.
REQ-034 Assert rst_n=0 during the first FLUSH cycle -> flush=0 and state IDLE on the next cycle; taken_cnt=0.
REQ-035 Preload taken_cnt to 0xFFFE, then issue 3 taken jumps -> taken_cnt reads 0xFFFF and stays there.
REQ-036 Hold br_valid=1 with changing rs1 while busy -> only the value present at the handshake is used; the next accept is at cycle 3 or 5 as per REQ-027.
